// File: rtl/serial_pkg.sv
// Shared constants and helpers for the serial-4 datapath blocks.
package serial_pkg;

    localparam int ADD_CYC = 4;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIG_W = cnt_w(ADD_CYC);

endpackage

// File: rtl/raster_cntr_serial.sv
// Digit/column/row raster counters for a digit-serial pixel stream, with
// in-image decode and end-of-row / end-of-image flags at word completion.
module raster_cntr_serial
    import serial_pkg::*;
#(
    parameter int IMG_SIZE = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic             clear,
    output logic [DIG_W-1:0] dig,
    output logic             in_img,
    output logic             word_done,
    output logic             last_col,
    output logic             last_img
);

    localparam int POS_W = cnt_w(IMG_SIZE);

    logic [POS_W-1:0] col_q, col_d;
    logic [POS_W-1:0] row_q, row_d;
    logic [DIG_W-1:0] dig_d;
    logic             dig_end;
    logic             col_end;
    logic             row_end;

    always_comb begin
        dig_end   = (dig == DIG_W'(ADD_CYC - 1));
        col_end   = (col_q == POS_W'(IMG_SIZE - 1));
        row_end   = (row_q == POS_W'(IMG_SIZE - 1));
        in_img    = (dig != '0) || (col_q != '0) || (row_q != '0);
        word_done = step && dig_end;
        last_col  = word_done && col_end;
        last_img  = last_col && row_end;
    end

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        dig_d = dig;
        col_d = col_q;
        row_d = row_q;
        if (step) begin
            if (dig_end) begin
                dig_d = '0;
                if (col_end) begin
                    col_d = '0;
                    row_d = row_end ? '0 : row_q + POS_W'(1);
                end else begin
                    col_d = col_q + POS_W'(1);
                end
            end else begin
                dig_d = dig + DIG_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            dig   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            dig   <= dig_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/deserializer_serial_4.sv
// Reassembles 4-digit serial activations into parallel words, one pulse per pixel.
// Optional DESER_ERR_CHECK_EN: sticky err and resync on a vld_in gap inside an image.
module deserializer_serial_4
    import serial_pkg::*;
#(
    parameter int IMG_SIZE = 32,
    parameter int CH       = 64,
    parameter int BW       = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          vld_in,
    input  logic [CH-1:0][BW-1:0]         in,
    output logic                          vld_out,
    output logic [CH-1:0][ADD_CYC*BW-1:0] out,
    output logic                          last_col,
    output logic                          last_img,
    output logic                          err
);

    typedef logic [CH-1:0][BW-1:0]               dig_vec_t;
    typedef logic [CH-1:0][(ADD_CYC-1)*BW-1:0]   part_vec_t;
    typedef logic [CH-1:0][ADD_CYC*BW-1:0]       word_vec_t;

    logic [DIG_W-1:0] dig;
    logic             in_img;
    logic             step;
    logic             clear;
    logic             word_done;
    logic             word_last_col;
    logic             word_last_img;
    dig_vec_t         dig_in;
    part_vec_t        asm_q;

    assign dig_in = in;

    // Once an image has started, digits are consumed every cycle unless a gap forces resync.
    assign step = (vld_in || in_img) && !clear;

    raster_cntr_serial #(
        .IMG_SIZE (IMG_SIZE)
    ) u_raster (
        .clock     (clock),
        .reset     (reset),
        .step      (step),
        .clear     (clear),
        .dig       (dig),
        .in_img    (in_img),
        .word_done (word_done),
        .last_col  (word_last_col),
        .last_img  (word_last_img)
    );

    // NOTE: the assembly register is left unreset; every digit slot is rewritten before it is read.
    always_ff @(posedge clock) begin
        if (step && !word_done) begin
            for (int c = 0; c < CH; c++) begin
                asm_q[c][int'(dig)*BW +: BW] <= dig_in[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_out  <= 1'b0;
            out      <= '0;
            last_col <= 1'b0;
            last_img <= 1'b0;
        end else begin
            vld_out  <= word_done;
            last_col <= word_last_col;
            last_img <= word_last_img;
            if (word_done) begin
                for (int c = 0; c < CH; c++) begin
                    out[c] <= {dig_in[c], asm_q[c]};
                end
            end
        end
    end

`ifdef DESER_ERR_CHECK_EN
    assign clear = in_img && !vld_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b1;
        end
    end
`else
    assign clear = 1'b0;
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer_serial_4.sv
// Directed self-checking bench for deserializer_serial_4 (IMG_SIZE=4, CH=2, BW=4).
module tb_deserializer_serial_4;

    localparam int IMG_SIZE = 4;
    localparam int CH       = 2;
    localparam int BW       = 4;
    localparam int NPIX     = IMG_SIZE * IMG_SIZE;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  vld_in = 1'b0;
    logic [CH-1:0][BW-1:0] in_d = '0;
    logic                  vld_out;
    logic [CH-1:0][4*BW-1:0] out_w;
    logic                  last_col;
    logic                  last_img;
    logic                  err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] q_out[$];
    bit          q_lc[$];
    bit          q_li[$];
    int          q_cyc[$];

    deserializer_serial_4 #(
        .IMG_SIZE (IMG_SIZE),
        .CH       (CH),
        .BW       (BW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .vld_in   (vld_in),
        .in       (in_d),
        .vld_out  (vld_out),
        .out      (out_w),
        .last_col (last_col),
        .last_img (last_img),
        .err      (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (vld_out) begin
            q_out.push_back(out_w);
            q_lc.push_back(last_col);
            q_li.push_back(last_img);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Image 0 pixel 0 carries the hand-picked digits; every other pixel a ramp.
    function automatic logic [15:0] pix_word(input int img, input int p, input int ch);
        logic [15:0] w;
        if (img == 0 && p == 0) begin
            w = (ch == 0) ? 16'h4321 : 16'hCDEF;
        end else begin
            w = 16'(img * 4096 + p * 273 + 5);
            if (ch == 1) w = ~w;
        end
        return w;
    endfunction

    task automatic drive(input bit v, input logic [15:0] w0, input logic [15:0] w1, input int k);
        vld_in   = v;
        in_d[0]  = w0[k*BW +: BW];
        in_d[1]  = w1[k*BW +: BW];
        @(posedge clock);
        #1;
    endtask

    task automatic send_pixels(input int img, input int p_from, input int p_to,
                               input int drop_p, input int drop_k);
        for (int p = p_from; p <= p_to; p++) begin
            for (int k = 0; k < 4; k++) begin
                drive(!(p == drop_p && k == drop_k), pix_word(img, p, 0), pix_word(img, p, 1), k);
            end
        end
    endtask

    task automatic idle(input int n);
        vld_in = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_q();
        q_out.delete();
        q_lc.delete();
        q_li.delete();
        q_cyc.delete();
    endtask

    task automatic check_image(input string tag, input int img, input int base, input int n);
        if (q_out.size() >= base + n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_out_p%0d", tag, i), q_out[base+i],
                      {pix_word(img, i, 1), pix_word(img, i, 0)});
                check($sformatf("%s_lc_p%0d", tag, i), q_lc[base+i], (i % IMG_SIZE) == IMG_SIZE - 1);
                check($sformatf("%s_li_p%0d", tag, i), q_li[base+i], i == NPIX - 1);
                if (i > 0) begin
                    check($sformatf("%s_gap_p%0d", tag, i), q_cyc[base+i] - q_cyc[base+i-1], 4);
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_vld_out", vld_out, 0);
        check("rst_out", out_w, 0);
        check("rst_last_col", last_col, 0);
        check("rst_last_img", last_img, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        idle(3);
        check("idle_vld_out", vld_out, 0);

        // Single pixel latency and hold, then finish image 0.
        clear_q();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h4321, 16'hCDEF, k);
            check($sformatf("p0_early_vld_d%0d", k), vld_out, 0);
        end
        drive(1'b1, 16'h4321, 16'hCDEF, 3);
        check("p0_vld_out", vld_out, 1);
        check("p0_out", out_w, 32'hCDEF_4321);
        check("p0_last_col", last_col, 0);
        check("p0_last_img", last_img, 0);
        drive(1'b1, pix_word(0, 1, 0), pix_word(0, 1, 1), 0);
        check("p0_pulse_len", vld_out, 0);
        check("p0_out_hold", out_w, 32'hCDEF_4321);
        for (int k = 1; k < 4; k++) drive(1'b1, pix_word(0, 1, 0), pix_word(0, 1, 1), k);
        send_pixels(0, 2, NPIX - 1, -1, -1);
        idle(4);
        check("img0_pulses", q_out.size(), NPIX);
        check_image("img0", 0, 0, NPIX);

        // Two images back to back, no bubble.
        clear_q();
        send_pixels(1, 0, NPIX - 1, -1, -1);
        send_pixels(2, 0, NPIX - 1, -1, -1);
        idle(4);
        check("b2b_pulses", q_out.size(), 2 * NPIX);
        check_image("b2b_a", 1, 0, NPIX);
        check_image("b2b_b", 2, NPIX, NPIX);
        if (q_cyc.size() > NPIX) check("b2b_seam_gap", q_cyc[NPIX] - q_cyc[NPIX-1], 4);

        // Reset at cycle 10 of an image, then a fresh image.
        clear_q();
        send_pixels(3, 0, 1, -1, -1);
        drive(1'b1, pix_word(3, 2, 0), pix_word(3, 2, 1), 0);
        drive(1'b1, pix_word(3, 2, 0), pix_word(3, 2, 1), 1);
        check("pre_rst_pulses", q_out.size(), 2);
        check("pre_rst_out", out_w, {pix_word(3, 1, 1), pix_word(3, 1, 0)});
        reset = 1'b1;
        drive(1'b1, pix_word(3, 2, 0), pix_word(3, 2, 1), 2);
        check("mid_rst_vld_out", vld_out, 0);
        check("mid_rst_out", out_w, 0);
        check("mid_rst_last_col", last_col, 0);
        check("mid_rst_last_img", last_img, 0);
        reset = 1'b0;
        idle(3);
        clear_q();
        send_pixels(4, 0, NPIX - 1, -1, -1);
        idle(4);
        check("post_rst_pulses", q_out.size(), NPIX);
        check_image("post_rst", 4, 0, NPIX);

        // vld_in drop at digit 2 of pixel 5.
        clear_q();
`ifdef DESER_ERR_CHECK_EN
        send_pixels(5, 0, 4, -1, -1);
        drive(1'b1, pix_word(5, 5, 0), pix_word(5, 5, 1), 0);
        drive(1'b1, pix_word(5, 5, 0), pix_word(5, 5, 1), 1);
        check("drop_err_before", err, 0);
        drive(1'b0, pix_word(5, 5, 0), pix_word(5, 5, 1), 2);
        check("drop_err_set", err, 1);
        idle(6);
        check("drop_err_sticky", err, 1);
        check("drop_pulses", q_out.size(), 5);
        check_image("drop", 5, 0, 5);
        clear_q();
        send_pixels(6, 0, NPIX - 1, -1, -1);
        idle(4);
        check("resync_pulses", q_out.size(), NPIX);
        check_image("resync", 6, 0, NPIX);
        check("resync_err_sticky", err, 1);
`else
        send_pixels(5, 0, NPIX - 1, 5, 2);
        idle(4);
        check("drop_err_low", err, 0);
        check("drop_pulses", q_out.size(), NPIX);
        check_image("drop", 5, 0, NPIX);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
